alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing the single clocked 8-bit `alu` between `NUM_REQ` requesters. Accepts one operation at a time over a valid/ready handshake, drives the ALU operand and select inputs, waits the ALU's pipeline latency, and returns the result and carry to the owning requester as a one-cycle response pulse. It sits between the ALU and its clients, such as the test-vector sequencer and the control logic.

---
 rtl/alu_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and widths for alu_arbiter
package alu_arb_pkg;

  localparam int ALU_W = 8;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_arb_state_e;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [SEL_W-1:0] sel;
  } alu_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot winner; pointer advances past the winner on grant_en
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       grant_en,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   cand;
  logic             found;

  // Scan upward from the pointer, wrapping, and keep the first requester seen.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                    = 1'b1;
        grant[cand[IDX_W-1:0]]   = 1'b1;
        grant_idx                = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (grant_en) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sequencer sharing one clocked ALU between NUM_REQ requesters
// Optional per-requester grant counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 1,
  parameter int STAT_W      = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][ALU_W-1:0]     req_a,
  input  logic [NUM_REQ-1:0][ALU_W-1:0]     req_b,
  input  logic [NUM_REQ-1:0][SEL_W-1:0]     req_sel,
  output logic [ALU_W-1:0]                  alu_a,
  output logic [ALU_W-1:0]                  alu_b,
  output logic [SEL_W-1:0]                  alu_sel,
  input  logic [ALU_W-1:0]                  alu_out,
  input  logic                              alu_carry,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [ALU_W-1:0]                  rsp_data,
  output logic                              rsp_carry
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][STAT_W-1:0]    grant_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  alu_arb_state_e   state;
  alu_op_t          cur_op;
  alu_op_t          win_op;
  logic [IDX_W-1:0] owner;
  logic [2:0]       wait_cnt;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               take;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clock    (clock),
    .reset    (reset),
    .req      (req_valid),
    .grant_en (take),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // Grants are only offered from IDLE and never while reset is held.
  assign req_ready = (state == IDLE && !reset) ? grant : '0;
  assign take      = |req_ready;

  always_comb begin
    win_op     = '0;
    win_op.a   = req_a[grant_idx];
    win_op.b   = req_b[grant_idx];
    win_op.sel = req_sel[grant_idx];
  end

  assign alu_a   = cur_op.a;
  assign alu_b   = cur_op.b;
  assign alu_sel = cur_op.sel;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cur_op    <= '0;
      owner     <= '0;
      wait_cnt  <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (take) begin
            cur_op   <= win_op;
            owner    <= grant_idx;
            wait_cnt <= 3'(ALU_LATENCY);
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (wait_cnt == 3'd0) begin
            rsp_data  <= alu_out;
            rsp_carry <= alu_carry;
            rsp_valid <= NUM_REQ'(1) << owner;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating per-requester handshake counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && req_valid[i] && grant_count[i] != '1) begin
          grant_count[i] <= grant_count[i] + STAT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter (latencies 1, 0 and 3; ALU_ARB_STATS_EN optional)
module tb_alu_arbiter;

  localparam int LAT = 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] d;
    logic       c;
  } op_t;

  typedef struct {
    int         owner;
    logic [7:0] d;
    logic       c;
    int         due;
  } rsp_t;

  logic clock;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0]       req_valid, req_ready, rsp_valid;
  logic [3:0][7:0]  req_a, req_b;
  logic [3:0][3:0]  req_sel;
  logic [7:0]       alu_a, alu_b, alu_out, rsp_data;
  logic [3:0]       alu_sel;
  logic             alu_carry, rsp_carry;

  logic [1:0][1:0]       sw_valid;
  logic [1:0][1:0][7:0]  sw_a, sw_b;
  logic [1:0][1:0][3:0]  sw_sel;
  logic [1:0] z_ready, t_ready, z_rsp_valid, t_rsp_valid;
  logic [7:0] z_alu_a, z_alu_b, z_out, z_rsp_data, t_alu_a, t_alu_b, t_out, t_rsp_data;
  logic [3:0] z_alu_sel, t_alu_sel;
  logic       z_carry, z_rsp_carry, t_carry, t_rsp_carry;
  logic [8:0] t_pipe [3];

`ifdef ALU_ARB_STATS_EN
  logic [3:0][1:0]  grant_count;
  logic [1:0][15:0] z_gc, t_gc;
`endif

  op_t  pend [4][$];
  rsp_t sq[$];
  rsp_t swq [2][$];
  int   exp_grant[$];
  int   hs_log[$];

  alu_arbiter #(.NUM_REQ(4), .ALU_LATENCY(LAT), .STAT_W(2)) u_dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_carry(rsp_carry)
`ifdef ALU_ARB_STATS_EN
    , .grant_count(grant_count)
`endif
  );

  alu_arbiter #(.NUM_REQ(2), .ALU_LATENCY(0)) u_lat0 (
    .clock(clock), .reset(reset), .req_valid(sw_valid[0]), .req_ready(z_ready),
    .req_a(sw_a[0]), .req_b(sw_b[0]), .req_sel(sw_sel[0]),
    .alu_a(z_alu_a), .alu_b(z_alu_b), .alu_sel(z_alu_sel), .alu_out(z_out), .alu_carry(z_carry),
    .rsp_valid(z_rsp_valid), .rsp_data(z_rsp_data), .rsp_carry(z_rsp_carry)
`ifdef ALU_ARB_STATS_EN
    , .grant_count(z_gc)
`endif
  );

  alu_arbiter #(.NUM_REQ(2), .ALU_LATENCY(3)) u_lat3 (
    .clock(clock), .reset(reset), .req_valid(sw_valid[1]), .req_ready(t_ready),
    .req_a(sw_a[1]), .req_b(sw_b[1]), .req_sel(sw_sel[1]),
    .alu_a(t_alu_a), .alu_b(t_alu_b), .alu_sel(t_alu_sel), .alu_out(t_out), .alu_carry(t_carry),
    .rsp_valid(t_rsp_valid), .rsp_data(t_rsp_data), .rsp_carry(t_rsp_carry)
`ifdef ALU_ARB_STATS_EN
    , .grant_count(t_gc)
`endif
  );

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    case (sel)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  // ALU models with one, zero and three pipeline stages.
  always @(posedge clock) {alu_carry, alu_out} <= alu_f(alu_a, alu_b, alu_sel);
  assign {z_carry, z_out} = alu_f(z_alu_a, z_alu_b, z_alu_sel);
  always @(posedge clock) begin
    t_pipe[0] <= alu_f(t_alu_a, t_alu_b, t_alu_sel);
    t_pipe[1] <= t_pipe[0];
    t_pipe[2] <= t_pipe[1];
  end
  assign {t_carry, t_out} = t_pipe[2];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_op(input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel, input logic [7:0] d, input logic c);
    op_t o;
    o.a = a; o.b = b; o.sel = sel; o.d = d; o.c = c;
    pend[r].push_back(o);
    exp_grant.push_back(r);
  endtask

  function automatic int outstanding();
    return pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size() + sq.size();
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (outstanding() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_drain_in_budget"}, n < budget, 1);
    chk({name, "_grants_left"}, exp_grant.size(), 0);
    exp_grant.delete();
  endtask

  task automatic apply_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    sq.delete();
    @(negedge clock);
    chk("rst_req_ready_now", req_ready, 0);
    chk("rst_rsp_valid_now", rsp_valid, 0);
    @(negedge clock);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_carry", rsp_carry, 0);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Driver: presents the head of each requester queue and logs handshakes.
  initial begin
    logic [3:0] hs;
    int idx;
    op_t o;
    req_valid = '0; req_a = '0; req_b = '0; req_sel = '0;
    forever begin
      @(negedge clock);
      hs = req_valid & req_ready;
      if (hs != 0) begin
        chk("handshake_onehot", $onehot(hs), 1);
        idx = 0;
        for (int i = 0; i < 4; i++) if (hs[i]) idx = i;
        if (exp_grant.size() == 0) chk("grant_unexpected", idx, -1);
        else chk("grant_order", idx, exp_grant.pop_front());
        if (pend[idx].size() != 0) begin
          o = pend[idx].pop_front();
          sq.push_back('{idx, o.d, o.c, cyc + LAT + 2});
        end
        hs_log.push_back(cyc);
      end
      @(posedge clock); #1;
      for (int i = 0; i < 4; i++) begin
        req_valid[i] = pend[i].size() > 0;
        if (pend[i].size() > 0) begin
          req_a[i] = pend[i][0].a; req_b[i] = pend[i][0].b; req_sel[i] = pend[i][0].sel;
        end
      end
    end
  end

  // Monitor for the main instance.
  always @(negedge clock) begin
    rsp_t e;
    if (|req_ready) chk("ready_onehot", $onehot(req_ready), 1);
    if (rsp_valid != 0) begin
      if (sq.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        e = sq.pop_front();
        chk("rsp_valid_owner", rsp_valid, 4'b1 << e.owner);
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_carry", rsp_carry, e.c);
        chk("rsp_cycle", cyc, e.due);
      end
    end
  end

  task automatic sw_mon(input int w, input logic [1:0] rv, input logic [7:0] d, input logic c);
    rsp_t e;
    if (rv != 0) begin
      if (swq[w].size() == 0) chk("sweep_rsp_unexpected", rv, 0);
      else begin
        e = swq[w].pop_front();
        chk("sweep_rsp_valid", rv, 2'b1 << e.owner);
        chk("sweep_rsp_data", d, e.d);
        chk("sweep_rsp_carry", c, e.c);
        chk("sweep_rsp_cycle", cyc, e.due);
      end
    end
  endtask

  always @(negedge clock) begin
    sw_mon(0, z_rsp_valid, z_rsp_data, z_rsp_carry);
    sw_mon(1, t_rsp_valid, t_rsp_data, t_rsp_carry);
  end

  task automatic sweep_op(input int w, input int r, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] sel, input logic [7:0] d, input logic c, input int lat);
    int n;
    @(posedge clock); #1;
    sw_valid[w][r] = 1'b1; sw_a[w][r] = a; sw_b[w][r] = b; sw_sel[w][r] = sel;
    @(negedge clock);
    chk("sweep_ready", (w == 0) ? z_ready[r] : t_ready[r], 1);
    swq[w].push_back('{r, d, c, cyc + lat});
    @(posedge clock); #1;
    sw_valid[w][r] = 1'b0;
    n = 0;
    while (swq[w].size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("sweep_in_budget", n < 20, 1);
  endtask

  initial begin
    int start;
    int n;
    reset = 1'b1;
    sw_valid = '0; sw_a = '0; sw_b = '0; sw_sel = '0;
    repeat (2) @(negedge clock);
    chk("init_req_ready", req_ready, 0);
    chk("init_alu_a", alu_a, 0);
    chk("init_alu_sel", alu_sel, 0);
    chk("init_rsp_valid", rsp_valid, 0);
    chk("init_rsp_data", rsp_data, 0);
    chk("init_rsp_carry", rsp_carry, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Single request: FF + 01 from requester 2.
    @(negedge clock);
    hs_log.delete();
    start = cyc + 1;
    push_op(2, 8'hFF, 8'h01, 4'd0, 8'h00, 1'b1);
    drain("single", 40);
    chk("single_hs_count", hs_log.size(), 1);
    if (hs_log.size() > 0) chk("single_ready_same_cycle", hs_log[0], start);

    // All four contend from a reset pointer.
    apply_reset();
    @(negedge clock);
    hs_log.delete();
    start = cyc + 1;
    push_op(0, 8'h12, 8'h34, 4'd0, 8'h46, 1'b0);
    push_op(1, 8'hF0, 8'h0F, 4'd2, 8'h00, 1'b0);
    push_op(2, 8'hA5, 8'h5A, 4'd4, 8'hFF, 1'b0);
    push_op(3, 8'h05, 8'h07, 4'd1, 8'hFE, 1'b1);
    push_op(0, 8'h80, 8'h80, 4'd0, 8'h00, 1'b1);
    drain("contend", 100);
    chk("contend_hs_count", hs_log.size(), 5);
    if (hs_log.size() == 5) begin
      chk("contend_first_grant", hs_log[0], start);
      for (int k = 1; k < 5; k++) chk("contend_spacing", hs_log[k] - hs_log[k-1], 4);
    end

    // Pointer wrap: grant 3, then 0 and 3 both valid -> 0 first.
    @(negedge clock);
    push_op(3, 8'h0F, 8'hF0, 4'd3, 8'hFF, 1'b0);
    n = 0;
    while (pend[3].size() != 0 && n < 20) begin @(negedge clock); n++; end
    chk("wrap_first_in_budget", n < 20, 1);
    push_op(0, 8'h01, 8'h01, 4'd0, 8'h02, 1'b0);
    push_op(3, 8'h33, 8'h11, 4'd1, 8'h22, 1'b0);
    drain("wrap", 60);

    // Reset during EXEC drops the operation; pointer restarts at 0.
    @(negedge clock);
    push_op(2, 8'h11, 8'h22, 4'd0, 8'h33, 1'b0);
    n = 0;
    while (pend[2].size() != 0 && n < 20) begin @(negedge clock); n++; end
    chk("rstop_grant_in_budget", n < 20, 1);
    push_op(1, 8'hC8, 8'h64, 4'd0, 8'h2C, 1'b1);
    push_op(3, 8'hFF, 8'hFF, 4'd2, 8'hFF, 1'b0);
    apply_reset();
    @(negedge clock);
    chk("rstop_no_rsp_a", rsp_valid, 0);
    @(negedge clock);
    chk("rstop_no_rsp_b", rsp_valid, 0);
    drain("rstop", 60);

    // Latency sweep on the ALU_LATENCY=0 and =3 instances.
    sweep_op(0, 1, 8'h7F, 8'h01, 4'd0, 8'h80, 1'b0, 2);
    sweep_op(1, 0, 8'h09, 8'h03, 4'd1, 8'h06, 1'b0, 5);
    sweep_op(1, 1, 8'hAA, 8'h55, 4'd3, 8'hFF, 1'b0, 5);

    // Five back-to-back grants to requester 1.
    apply_reset();
    @(negedge clock);
    hs_log.delete();
    push_op(1, 8'h01, 8'h01, 4'd0, 8'h02, 1'b0);
    push_op(1, 8'h02, 8'h02, 4'd0, 8'h04, 1'b0);
    push_op(1, 8'h03, 8'h03, 4'd0, 8'h06, 1'b0);
    push_op(1, 8'h04, 8'h04, 4'd0, 8'h08, 1'b0);
    push_op(1, 8'h05, 8'h05, 4'd0, 8'h0A, 1'b0);
    drain("repeat", 100);
    chk("repeat_hs_count", hs_log.size(), 5);
`ifdef ALU_ARB_STATS_EN
    chk("stats_count1_saturated", grant_count[1], 2'b11);
    chk("stats_count0_zero", grant_count[0], 2'b00);
`endif

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
